proc_arbiter: RTL

- Shares one processing engine (threshold / brightness datapath) between NUM_SLV slave requesters.
- Round-robin arbitration per image job. The winner's mode and proc_val are latched and presented to the engine; its pixel stream is forwarded through a one-stage register.
- The grant is held until the engine signals job completion (mstr_data_cmplt) or a watchdog timeout fires.
- Sits between the slave-side ports and the processing engine's slvx_* inputs. Back-pressure is taken from the output FIFO.

---
 rtl/proc_arbiter_if.sv | 41 ++++
 rtl/proc_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/proc_arbiter_if.sv
// Signal bundle between the requesters / processing engine and proc_arbiter.
// The arbiter uses the slave view; requesters and engine (or a bench) use master.
interface proc_arbiter_if #(
   parameter int D_WIDTH = 32,
   parameter int NUM_SLV = 3
);
   logic [NUM_SLV-1:0]         slv_req;
   logic [2*NUM_SLV-1:0]       slv_mode;
   logic [8*NUM_SLV-1:0]       slv_proc_val;
   logic [D_WIDTH*NUM_SLV-1:0] slv_data;
   logic [NUM_SLV-1:0]         slv_data_valid;
   logic [NUM_SLV-1:0]         slv_gnt;
   logic [NUM_SLV-1:0]         slv_ready;
   logic [NUM_SLV-1:0]         slv_done;
   logic [NUM_SLV-1:0]         slv_err;
   logic                       fifo_full;
   logic                       eng_cmplt;
   logic [1:0]                 eng_mode;
   logic [7:0]                 eng_proc_val;
   logic [D_WIDTH-1:0]         eng_data;
   logic                       eng_data_valid;
   logic                       busy;
   logic [1:0]                 cur_id;
   logic [15:0]                job_count;

   modport slave (
      input  slv_req, slv_mode, slv_proc_val, slv_data, slv_data_valid,
             fifo_full, eng_cmplt,
      output slv_gnt, slv_ready, slv_done, slv_err,
             eng_mode, eng_proc_val, eng_data, eng_data_valid,
             busy, cur_id, job_count
   );

   modport master (
      output slv_req, slv_mode, slv_proc_val, slv_data, slv_data_valid,
             fifo_full, eng_cmplt,
      input  slv_gnt, slv_ready, slv_done, slv_err,
             eng_mode, eng_proc_val, eng_data, eng_data_valid,
             busy, cur_id, job_count
   );
endinterface

// File: rtl/proc_arbiter.sv
// Round-robin arbiter sharing one threshold/brightness engine among NUM_SLV
// requesters; the winner's pixel stream is forwarded through one register stage.
module proc_arbiter #(
   parameter int D_WIDTH = 32,
   parameter int NUM_SLV = 3,
   parameter int TIMEOUT = 1024
) (
   input logic           clk,
   input logic           rst_n,
   proc_arbiter_if.slave bus
);

   localparam int                 WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [NUM_SLV-1:0] ONE     = NUM_SLV'(1);

   typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM, S_DONE} state_t;

   state_t             state;
   logic [1:0]         last_id;
   logic [1:0]         cur_id_q;
   logic [WD_W-1:0]    wd;
   logic [NUM_SLV-1:0] gnt_q;
   logic [NUM_SLV-1:0] done_q;
   logic [NUM_SLV-1:0] err_q;
   logic [1:0]         eng_mode_q;
   logic [7:0]         eng_proc_val_q;
   logic [D_WIDTH-1:0] eng_data_q;
   logic               eng_data_valid_q;
   logic [15:0]        job_count_q;

   logic [1:0]         next_id;
   logic [1:0]         cand;
   logic               req_any;
   logic [1:0]         sel_mode;
   logic [7:0]         sel_val;
   logic [D_WIDTH-1:0] sel_data;
   logic [NUM_SLV-1:0] ready;
   logic [NUM_SLV-1:0] cur_oh;
   logic               accept;
   logic               mode_bad;

   // Round robin: first requester found scanning upward from last_id + 1.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      next_id = last_id;
      cand    = '0;
      req_any = 1'b0;
      for (int k = 1; k <= NUM_SLV; k++) begin
         cand = 2'((int'(last_id) + k) % NUM_SLV);
         for (int i = 0; i < NUM_SLV; i++) begin
            if (!req_any && cand == 2'(i) && bus.slv_req[i]) begin
               req_any = 1'b1;
               next_id = cand;
            end
         end
      end
   end

   always_comb begin
      sel_mode = '0;
      sel_val  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (cur_id_q == 2'(i)) begin
            sel_mode = bus.slv_mode[2*i +: 2];
            sel_val  = bus.slv_proc_val[8*i +: 8];
            sel_data = bus.slv_data[D_WIDTH*i +: D_WIDTH];
         end
      end
   end

   assign cur_oh   = ONE << cur_id_q;
   assign ready    = gnt_q & {NUM_SLV{~bus.fifo_full}};
   assign accept   = |(ready & bus.slv_data_valid);
   assign mode_bad = (sel_mode == 2'b00) || (sel_mode == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         last_id          <= 2'(NUM_SLV - 1);
         cur_id_q         <= '0;
         wd               <= '0;
         gnt_q            <= '0;
         done_q           <= '0;
         err_q            <= '0;
         eng_mode_q       <= '0;
         eng_proc_val_q   <= '0;
         eng_data_q       <= '0;
         eng_data_valid_q <= 1'b0;
         job_count_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         done_q           <= '0;
         err_q            <= '0;
         eng_data_valid_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_any) begin
                  cur_id_q <= next_id;
                  state    <= S_CFG;
               end
            end
            S_CFG: begin
               if (mode_bad) begin
                  done_q <= cur_oh;
                  err_q  <= cur_oh;
                  state  <= S_DONE;
               end else begin
                  gnt_q          <= cur_oh;
                  eng_mode_q     <= sel_mode;
                  eng_proc_val_q <= sel_val;
                  wd             <= '0;
                  state          <= S_STREAM;
               end
            end
            S_STREAM: begin
               // A word accepted alongside eng_cmplt is still forwarded, never dropped.
               eng_data_q       <= sel_data;
               eng_data_valid_q <= accept;
               if (bus.eng_cmplt || (!accept && wd == WD_LAST)) begin
                  gnt_q      <= '0;
                  eng_mode_q <= '0;
                  done_q     <= cur_oh;
                  err_q      <= bus.eng_cmplt ? '0 : cur_oh;
                  state      <= S_DONE;
               end else if (accept) begin
                  wd <= '0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_DONE: begin
               last_id <= cur_id_q;
               if (job_count_q != 16'hFFFF) job_count_q <= job_count_q + 16'd1;
               wd      <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.slv_gnt        = gnt_q;
   assign bus.slv_ready      = ready;
   assign bus.slv_done       = done_q;
   assign bus.slv_err        = err_q;
   assign bus.eng_mode       = eng_mode_q;
   assign bus.eng_proc_val   = eng_proc_val_q;
   assign bus.eng_data       = eng_data_q;
   assign bus.eng_data_valid = eng_data_valid_q;
   assign bus.busy           = (state != S_IDLE);
   assign bus.cur_id         = cur_id_q;
   assign bus.job_count      = job_count_q;

endmodule
